// File: rtl/rv_plic_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv_plic_ctrl_pkg
// Shared types and helpers for the per-target PLIC claim/complete controller.
//   - claim_state_e : claim sequencing FSM states (IDLE -> ACK -> SETTLE)
//   - id_width()    : ID width for a given source count (ID 0 = no interrupt)
//   - id_to_onehot(): ID (1-based) to one-hot source vector, ID 0 -> all zero
// -----------------------------------------------------------------------------
package rv_plic_ctrl_pkg;

    // Upper bound on the source count; one-hot vectors are produced at this
    // width and size-cast down to N_SOURCE by the caller.
    localparam int MAX_SOURCE = 1024;

    typedef enum logic [1:0] {
        CLAIM_IDLE   = 2'd0,
        CLAIM_ACK    = 2'd1,
        CLAIM_SETTLE = 2'd2
    } claim_state_e;

    function automatic int id_width(input int n_source);
        return $clog2(n_source + 1);
    endfunction

    // ID i maps to bit i-1; ID 0 and IDs beyond MAX_SOURCE give no bit.
    function automatic logic [MAX_SOURCE-1:0] id_to_onehot(input logic [31:0] id);
        logic [MAX_SOURCE-1:0] oh;
        oh = '0;
        if (id != 32'd0) begin
            oh = {{(MAX_SOURCE-1){1'b0}}, 1'b1} << (id - 32'd1);
        end
        return oh;
    endfunction

endpackage

// File: rtl/rv_plic_prio_max.sv
// -----------------------------------------------------------------------------
// rv_plic_prio_max
// Combinational max-priority selector. Each level of a binary tree keeps the
// higher-priority valid child; on equal priority the left child (lower ID)
// is kept, so ties resolve to the lowest ID.
// Ports:
//   cand_i      [N_SOURCE]        candidate mask (already filtered)
//   prio_i      [N_SOURCE*PRIO_W] packed priorities, source i at [i*PRIO_W +: PRIO_W]
//   win_valid_o                   at least one candidate present
//   win_id_o    [ID_W]            winning ID (source index + 1), 0 when none
// -----------------------------------------------------------------------------
module rv_plic_prio_max
    import rv_plic_ctrl_pkg::*;
#(
    parameter int N_SOURCE = 32,
    parameter int PRIO_W   = 3,
    parameter int ID_W     = id_width(N_SOURCE)
) (
    input  logic [N_SOURCE-1:0]        cand_i,
    input  logic [N_SOURCE*PRIO_W-1:0] prio_i,
    output logic                       win_valid_o,
    output logic [ID_W-1:0]            win_id_o
);

    localparam int LEVELS = $clog2(N_SOURCE);
    localparam int N_LEAF = 1 << LEVELS;

    genvar gl, gi;

    // Levels 0 .. LEVELS-1; the root merge is done separately below so that
    // no unused priority is carried out of the tree.
    for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
        localparam int W = N_LEAF >> gl;
        logic [W-1:0]      v;
        logic [PRIO_W-1:0] p  [W];
        logic [ID_W-1:0]   id [W];

        if (gl == 0) begin : g_leaf
            for (gi = 0; gi < W; gi++) begin : g_node
                if (gi < N_SOURCE) begin : g_src
                    assign v[gi]  = cand_i[gi];
                    assign p[gi]  = cand_i[gi] ? prio_i[gi*PRIO_W +: PRIO_W] : '0;
                    assign id[gi] = ID_W'(gi + 1);
                end else begin : g_pad
                    assign v[gi]  = 1'b0;
                    assign p[gi]  = '0;
                    assign id[gi] = '0;
                end
            end
        end else begin : g_merge
            for (gi = 0; gi < W; gi++) begin : g_node
                logic take_right;
                assign take_right = g_lvl[gl-1].v[2*gi+1] &&
                                    (!g_lvl[gl-1].v[2*gi] ||
                                     (g_lvl[gl-1].p[2*gi+1] > g_lvl[gl-1].p[2*gi]));
                assign v[gi]  = g_lvl[gl-1].v[2*gi] | g_lvl[gl-1].v[2*gi+1];
                assign p[gi]  = take_right ? g_lvl[gl-1].p[2*gi+1]  : g_lvl[gl-1].p[2*gi];
                assign id[gi] = take_right ? g_lvl[gl-1].id[2*gi+1] : g_lvl[gl-1].id[2*gi];
            end
        end
    end

    if (LEVELS == 0) begin : g_single
        assign win_valid_o = cand_i[0];
        assign win_id_o    = cand_i[0] ? ID_W'(1) : '0;
    end else begin : g_root
        logic root_right;
        assign root_right  = g_lvl[LEVELS-1].v[1] &&
                             (!g_lvl[LEVELS-1].v[0] ||
                              (g_lvl[LEVELS-1].p[1] > g_lvl[LEVELS-1].p[0]));
        assign win_valid_o = g_lvl[LEVELS-1].v[0] | g_lvl[LEVELS-1].v[1];
        assign win_id_o    = !win_valid_o ? '0 :
                             root_right   ? g_lvl[LEVELS-1].id[1] : g_lvl[LEVELS-1].id[0];
    end

endmodule

// File: rtl/rv_plic_claim_ctrl.sv
// -----------------------------------------------------------------------------
// rv_plic_claim_ctrl
// Per-target claim/complete controller. Arbitrates the enabled, pending,
// not-in-service sources above threshold, drives the target IRQ, and turns
// claim reads / complete writes into one-hot strobes back to the gateway.
//
// Build option: RV_PLIC_COMPLETE_CHECK_EN
//   defined   : a complete for an in-range ID that is not in service is
//               dropped and flagged on err_o.
//   undefined : every in-range complete is forwarded; err_o flags only
//               out-of-range IDs.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   ip_i, ie_i, prio_i, threshold_i     arbitration inputs
//   claim_req_i / claim_ready_o         claim read handshake
//   claim_ack_o, claim_id_o             claim response (one-cycle ack)
//   complete_req_i, complete_id_i       complete write
//   claim_o, complete_o                 one-hot strobes to gateway
//   irq_o, irq_id_o                     registered winner
//   err_o                               illegal complete pulse
// -----------------------------------------------------------------------------
module rv_plic_claim_ctrl
    import rv_plic_ctrl_pkg::*;
#(
    parameter int N_SOURCE = 32,
    parameter int PRIO_W   = 3,
    parameter int ID_W     = id_width(N_SOURCE)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_SOURCE-1:0]        ip_i,
    input  logic [N_SOURCE-1:0]        ie_i,
    input  logic [N_SOURCE*PRIO_W-1:0] prio_i,
    input  logic [PRIO_W-1:0]          threshold_i,
    input  logic                       claim_req_i,
    output logic                       claim_ready_o,
    output logic                       claim_ack_o,
    output logic [ID_W-1:0]            claim_id_o,
    input  logic                       complete_req_i,
    input  logic [ID_W-1:0]            complete_id_i,
    output logic [N_SOURCE-1:0]        claim_o,
    output logic [N_SOURCE-1:0]        complete_o,
    output logic                       irq_o,
    output logic [ID_W-1:0]            irq_id_o,
    output logic                       err_o
);

    // ---------------------------------------------------------------- state
    claim_state_e          state_reg, state_next;
    logic [N_SOURCE-1:0]   in_svc_reg, in_svc_next;
    logic                  irq_reg;
    logic [ID_W-1:0]       irq_id_reg;
    logic                  claim_ack_reg;
    logic [ID_W-1:0]       claim_id_reg, claim_id_next;
    logic [N_SOURCE-1:0]   claim_oh_reg, claim_oh_next;
    logic [N_SOURCE-1:0]   complete_oh_reg, complete_oh_next;
    logic                  err_reg, err_next;

    logic                  claim_ready;
    logic                  claim_accept;

    // ---------------------------------------------------------- arbitration
    logic [N_SOURCE-1:0]   cand;
    logic                  win_valid;
    logic [ID_W-1:0]       win_id;

    genvar gi;
    for (gi = 0; gi < N_SOURCE; gi++) begin : g_cand
        assign cand[gi] = ip_i[gi] & ie_i[gi] & ~in_svc_reg[gi] &
                          (prio_i[gi*PRIO_W +: PRIO_W] > threshold_i);
    end

    rv_plic_prio_max #(
        .N_SOURCE (N_SOURCE),
        .PRIO_W   (PRIO_W),
        .ID_W     (ID_W)
    ) u_prio_max (
        .cand_i      (cand),
        .prio_i      (prio_i),
        .win_valid_o (win_valid),
        .win_id_o    (win_id)
    );

    // ------------------------------------------------------------ claim FSM
    always_comb begin
        state_next    = state_reg;
        claim_ready   = 1'b0;
        claim_accept  = 1'b0;
        claim_id_next = claim_id_reg;
        claim_oh_next = '0;
        case (state_reg)
            CLAIM_IDLE: begin
                claim_ready = 1'b1;
                if (claim_req_i) begin
                    claim_accept  = 1'b1;
                    claim_id_next = irq_id_reg;
                    claim_oh_next = N_SOURCE'(id_to_onehot(32'(irq_id_reg)));
                    state_next    = CLAIM_ACK;
                end
            end
            CLAIM_ACK:    state_next = CLAIM_SETTLE;
            // Lets the arbitration register pick up the new in_svc before
            // the next claim can sample irq_id.
            CLAIM_SETTLE: state_next = CLAIM_IDLE;
            default:      state_next = CLAIM_IDLE;
        endcase
    end

    // -------------------------------------------------------------- complete
    logic [N_SOURCE-1:0] cmp_oh;
    logic                cmp_in_range;
    logic                cmp_ok;

    always_comb begin
        cmp_oh       = N_SOURCE'(id_to_onehot(32'(complete_id_i)));
        cmp_in_range = (complete_id_i != '0) && (complete_id_i <= ID_W'(N_SOURCE));
`ifdef RV_PLIC_COMPLETE_CHECK_EN
        cmp_ok       = complete_req_i & cmp_in_range & (|(cmp_oh & in_svc_reg));
`else
        cmp_ok       = complete_req_i & cmp_in_range;
`endif
        err_next         = complete_req_i & ~cmp_ok;
        complete_oh_next = cmp_ok ? cmp_oh : '0;
        // claim_oh_reg is non-zero only in the ACK cycle, so the claimed
        // source enters service at the end of ACK. A claim and a complete
        // never target the same source in one cycle.
        in_svc_next      = (in_svc_reg | claim_oh_reg) & ~complete_oh_next;
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= CLAIM_IDLE;
            in_svc_reg      <= '0;
            irq_reg         <= 1'b0;
            irq_id_reg      <= '0;
            claim_ack_reg   <= 1'b0;
            claim_id_reg    <= '0;
            claim_oh_reg    <= '0;
            complete_oh_reg <= '0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            in_svc_reg      <= in_svc_next;
            irq_reg         <= win_valid;
            irq_id_reg      <= win_id;
            claim_ack_reg   <= claim_accept;
            claim_id_reg    <= claim_id_next;
            claim_oh_reg    <= claim_oh_next;
            complete_oh_reg <= complete_oh_next;
            err_reg         <= err_next;
        end
    end

    // Ready is held low while reset is asserted so every output reads 0.
    assign claim_ready_o = claim_ready & ~rst_i;
    assign claim_ack_o   = claim_ack_reg;
    assign claim_id_o    = claim_id_reg;
    assign claim_o       = claim_oh_reg;
    assign complete_o    = complete_oh_reg;
    assign irq_o         = irq_reg;
    assign irq_id_o      = irq_id_reg;
    assign err_o         = err_reg;

endmodule

// File: tb/tb_rv_plic_claim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv_plic_claim_ctrl
// Scenario tasks push expected results into queues as they drive stimulus and
// pop/compare them when the DUT responds. One line per transaction.
// -----------------------------------------------------------------------------
module tb_rv_plic_claim_ctrl;

    localparam int N  = 32;
    localparam int PW = 3;
    localparam int IW = 6;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    ip_i, ie_i;
    logic [N*PW-1:0] prio_i;
    logic [PW-1:0]   threshold_i;
    logic            claim_req_i;
    logic            claim_ready_o, claim_ack_o;
    logic [IW-1:0]   claim_id_o;
    logic            complete_req_i;
    logic [IW-1:0]   complete_id_i;
    logic [N-1:0]    claim_o, complete_o;
    logic            irq_o;
    logic [IW-1:0]   irq_id_o;
    logic            err_o;

    logic [PW-1:0]   prio_tb [N];

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed { logic irq; logic [IW-1:0] id; } irq_exp_t;
    typedef struct packed { logic [IW-1:0] id; logic [N-1:0] oh; } claim_exp_t;
    typedef struct packed { logic [N-1:0] oh; logic err; } cmp_exp_t;

    irq_exp_t   irq_q   [$];
    claim_exp_t claim_q [$];
    cmp_exp_t   cmp_q   [$];

    always #5 clk_i = ~clk_i;

    always_comb begin
        prio_i = '0;
        for (int i = 0; i < N; i++) prio_i[i*PW +: PW] = prio_tb[i];
    end

    rv_plic_claim_ctrl #(.N_SOURCE(N), .PRIO_W(PW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ip_i           (ip_i),
        .ie_i           (ie_i),
        .prio_i         (prio_i),
        .threshold_i    (threshold_i),
        .claim_req_i    (claim_req_i),
        .claim_ready_o  (claim_ready_o),
        .claim_ack_o    (claim_ack_o),
        .claim_id_o     (claim_id_o),
        .complete_req_i (complete_req_i),
        .complete_id_i  (complete_id_i),
        .claim_o        (claim_o),
        .complete_o     (complete_o),
        .irq_o          (irq_o),
        .irq_id_o       (irq_id_o),
        .err_o          (err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (claim_ready_o !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        tests_run++;
        if (claim_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", claim_ready_o, n);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; ip_i = '0; ie_i = '0; threshold_i = '0;
        claim_req_i = 1'b0; complete_req_i = 1'b0; complete_id_i = '0;
        for (int i = 0; i < N; i++) prio_tb[i] = '0;
        tick(); tick();
        tests_run++;
        if ({claim_ack_o, irq_o, err_o} !== 3'b000 || claim_o !== '0 || complete_o !== '0 || irq_id_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_hold: ack=%b irq=%b err=%b claim=%h cmp=%h id=%0d, required all 0",
                     claim_ack_o, irq_o, err_o, claim_o, complete_o, irq_id_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        tests_run++;
        if (claim_ready_o !== 1'b1 || irq_o !== 1'b0 || irq_id_o !== '0 || claim_o !== '0 || complete_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b irq=%b id=%0d claim=%h cmp=%h, required ready=1 rest 0",
                     claim_ready_o, irq_o, irq_id_o, claim_o, complete_o);
        end
        $display("[TB] reset: ready=%b irq=%b irq_id=%0d", claim_ready_o, irq_o, irq_id_o);
    endtask

    task automatic test_arbitration();
        irq_exp_t e;
        ie_i = '1; threshold_i = 3'd1;
        prio_tb[3] = 3'd2; prio_tb[5] = 3'd5; ip_i = 32'h28;
        irq_q.push_back('{irq: 1'b1, id: 6'd6});
        prio_tb[3] = 3'd2;
        tick();
        e = irq_q.pop_front();
        tests_run++;
        if (irq_o !== e.irq || irq_id_o !== e.id) begin
            tests_failed++;
            $display("FAIL arb_max: irq=%b id=%0d, required irq=%b id=%0d", irq_o, irq_id_o, e.irq, e.id);
        end
        $display("[TB] arb prio 2/5 -> irq_id=%0d", irq_id_o);

        prio_tb[3] = 3'd4; prio_tb[5] = 3'd4;
        irq_q.push_back('{irq: 1'b1, id: 6'd4});
        tick();
        e = irq_q.pop_front();
        tests_run++;
        if (irq_o !== e.irq || irq_id_o !== e.id) begin
            tests_failed++;
            $display("FAIL arb_tie: irq=%b id=%0d, required irq=%b id=%0d", irq_o, irq_id_o, e.irq, e.id);
        end
        $display("[TB] arb tie 4/4 -> irq_id=%0d", irq_id_o);

        ie_i = ~32'h08;
        irq_q.push_back('{irq: 1'b1, id: 6'd6});
        tick();
        e = irq_q.pop_front();
        tests_run++;
        if (irq_o !== e.irq || irq_id_o !== e.id) begin
            tests_failed++;
            $display("FAIL arb_ie_mask: irq=%b id=%0d, required irq=%b id=%0d", irq_o, irq_id_o, e.irq, e.id);
        end
        $display("[TB] arb ie mask -> irq_id=%0d", irq_id_o);
        ie_i = '1;
    endtask

    task automatic test_threshold();
        irq_exp_t e;
        ip_i = 32'h20; prio_tb[5] = 3'd5; threshold_i = 3'd5;
        irq_q.push_back('{irq: 1'b0, id: 6'd0});
        tick();
        e = irq_q.pop_front();
        tests_run++;
        if (irq_o !== e.irq || irq_id_o !== e.id) begin
            tests_failed++;
            $display("FAIL thr_equal: irq=%b id=%0d, required irq=%b id=%0d", irq_o, irq_id_o, e.irq, e.id);
        end
        $display("[TB] threshold 5, prio 5 -> irq=%b", irq_o);

        threshold_i = 3'd4;
        irq_q.push_back('{irq: 1'b1, id: 6'd6});
        tick();
        e = irq_q.pop_front();
        tests_run++;
        if (irq_o !== e.irq || irq_id_o !== e.id) begin
            tests_failed++;
            $display("FAIL thr_below: irq=%b id=%0d, required irq=%b id=%0d", irq_o, irq_id_o, e.irq, e.id);
        end
        $display("[TB] threshold 4, prio 5 -> irq=%b id=%0d", irq_o, irq_id_o);
    endtask

    task automatic test_claim();
        irq_exp_t   ei;
        claim_exp_t ec;
        prio_tb[3] = 3'd2; prio_tb[5] = 3'd5; threshold_i = 3'd1; ip_i = 32'h28;
        tick();
        wait_ready();

        // First claim: winner 6, requester keeps claim_req_i high.
        claim_req_i = 1'b1;
        claim_q.push_back('{id: 6'd6, oh: 32'h20});
        tick();
        ec = claim_q.pop_front();
        tests_run++;
        if (claim_ack_o !== 1'b1 || claim_id_o !== ec.id || claim_o !== ec.oh || claim_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL claim_6: ack=%b id=%0d oh=%h ready=%b, required ack=1 id=%0d oh=%h ready=0",
                     claim_ack_o, claim_id_o, claim_o, claim_ready_o, ec.id, ec.oh);
        end
        $display("[TB] claim -> ack=%b id=%0d claim_o=%h", claim_ack_o, claim_id_o, claim_o);
        tick();
        tests_run++;
        if (claim_ack_o !== 1'b0 || claim_o !== '0 || claim_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL claim_settle: ack=%b oh=%h ready=%b, required 0/0/0", claim_ack_o, claim_o, claim_ready_o);
        end
        irq_q.push_back('{irq: 1'b1, id: 6'd4});
        tick();
        ei = irq_q.pop_front();
        tests_run++;
        if (claim_ready_o !== 1'b1 || irq_id_o !== ei.id || irq_o !== ei.irq) begin
            tests_failed++;
            $display("FAIL claim_ready_t3: ready=%b irq_id=%0d, required ready=1 irq_id=%0d", claim_ready_o, irq_id_o, ei.id);
        end

        // Held request is accepted again three cycles after the first.
        claim_q.push_back('{id: 6'd4, oh: 32'h08});
        tick();
        ec = claim_q.pop_front();
        tests_run++;
        if (claim_ack_o !== 1'b1 || claim_id_o !== ec.id || claim_o !== ec.oh) begin
            tests_failed++;
            $display("FAIL claim_4: ack=%b id=%0d oh=%h, required ack=1 id=%0d oh=%h",
                     claim_ack_o, claim_id_o, claim_o, ec.id, ec.oh);
        end
        $display("[TB] claim -> ack=%b id=%0d claim_o=%h", claim_ack_o, claim_id_o, claim_o);
        claim_req_i = 1'b0;
        irq_q.push_back('{irq: 1'b0, id: 6'd0});
        tick(); tick();
        ei = irq_q.pop_front();
        tests_run++;
        if (irq_o !== ei.irq || irq_id_o !== ei.id) begin
            tests_failed++;
            $display("FAIL in_svc_excl: irq=%b id=%0d, required irq=%b id=%0d", irq_o, irq_id_o, ei.irq, ei.id);
        end

        // Nothing left to claim: ack with ID 0 and no strobe.
        claim_req_i = 1'b1;
        claim_q.push_back('{id: 6'd0, oh: 32'h0});
        tick();
        ec = claim_q.pop_front();
        tests_run++;
        if (claim_ack_o !== 1'b1 || claim_id_o !== ec.id || claim_o !== ec.oh) begin
            tests_failed++;
            $display("FAIL claim_none: ack=%b id=%0d oh=%h, required ack=1 id=%0d oh=%h",
                     claim_ack_o, claim_id_o, claim_o, ec.id, ec.oh);
        end
        $display("[TB] claim -> ack=%b id=%0d claim_o=%h", claim_ack_o, claim_id_o, claim_o);
        claim_req_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        cmp_exp_t e;
        irq_exp_t ei;
        logic [IW-1:0] ids [3];
        ids[0] = 6'd6; ids[1] = 6'd4; ids[2] = 6'd0;
        cmp_q.push_back('{oh: 32'h20, err: 1'b0});
        cmp_q.push_back('{oh: 32'h08, err: 1'b0});
        cmp_q.push_back('{oh: 32'h00, err: 1'b0});
        for (int k = 0; k < 3; k++) begin
            complete_req_i = (k < 2);
            complete_id_i  = ids[k];
            tick();
            e = cmp_q.pop_front();
            tests_run++;
            if (complete_o !== e.oh || err_o !== e.err) begin
                tests_failed++;
                $display("FAIL b2b_complete_%0d: complete_o=%h err=%b, required %h err=%b",
                         k, complete_o, err_o, e.oh, e.err);
            end
            $display("[TB] complete req=%b id=%0d -> complete_o=%h err=%b", complete_req_i, ids[k], complete_o, err_o);
        end
        complete_req_i = 1'b0;
        ei = '{irq: 1'b1, id: 6'd6};
        tests_run++;
        if (irq_o !== ei.irq || irq_id_o !== ei.id) begin
            tests_failed++;
            $display("FAIL rearm_after_complete: irq=%b id=%0d, required irq=%b id=%0d", irq_o, irq_id_o, ei.irq, ei.id);
        end
    endtask

    task automatic test_complete_err();
        cmp_exp_t e;
        logic [IW-1:0] ids [4];
        ids[0] = 6'd0; ids[1] = 6'd33; ids[2] = 6'd32; ids[3] = 6'd2;
        cmp_q.push_back('{oh: 32'h0, err: 1'b1});
        cmp_q.push_back('{oh: 32'h0, err: 1'b1});
`ifdef RV_PLIC_COMPLETE_CHECK_EN
        cmp_q.push_back('{oh: 32'h0, err: 1'b1});
        cmp_q.push_back('{oh: 32'h0, err: 1'b1});
`else
        cmp_q.push_back('{oh: 32'h8000_0000, err: 1'b0});
        cmp_q.push_back('{oh: 32'h2, err: 1'b0});
`endif
        for (int k = 0; k < 4; k++) begin
            complete_req_i = 1'b1;
            complete_id_i  = ids[k];
            tick();
            e = cmp_q.pop_front();
            tests_run++;
            if (complete_o !== e.oh || err_o !== e.err) begin
                tests_failed++;
                $display("FAIL complete_id_%0d: complete_o=%h err=%b, required %h err=%b",
                         ids[k], complete_o, err_o, e.oh, e.err);
            end
            $display("[TB] complete id=%0d -> complete_o=%h err=%b", ids[k], complete_o, err_o);
        end
        complete_req_i = 1'b0;
        complete_id_i  = '0;
        tick();
        tests_run++;
        if (complete_o !== '0 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL complete_idle: complete_o=%h err=%b, required 0/0", complete_o, err_o);
        end
    endtask

    task automatic test_reset_mid_claim();
        wait_ready();
        claim_req_i = 1'b1;
        tick();
        tests_run++;
        if (claim_ack_o !== 1'b1 || claim_o !== 32'h20) begin
            tests_failed++;
            $display("FAIL midclaim_ack: ack=%b oh=%h, required ack=1 oh=00000020", claim_ack_o, claim_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        tests_run++;
        if ({claim_ready_o, claim_ack_o, irq_o, err_o} !== 4'b0000 || claim_o !== '0 ||
            complete_o !== '0 || claim_id_o !== '0 || irq_id_o !== '0) begin
            tests_failed++;
            $display("FAIL midclaim_reset: ready=%b ack=%b irq=%b err=%b claim=%h cmp=%h cid=%0d iid=%0d, required all 0",
                     claim_ready_o, claim_ack_o, irq_o, err_o, claim_o, complete_o, claim_id_o, irq_id_o);
        end
        claim_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        tests_run++;
        if (claim_ready_o !== 1'b1 || claim_ack_o !== 1'b0 || irq_id_o !== 6'd6) begin
            tests_failed++;
            $display("FAIL midclaim_recover: ready=%b ack=%b irq_id=%0d, required ready=1 ack=0 irq_id=6",
                     claim_ready_o, claim_ack_o, irq_id_o);
        end
        $display("[TB] reset during ACK -> ready=%b irq_id=%0d", claim_ready_o, irq_id_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arbitration();
        test_threshold();
        test_claim();
        test_back_to_back();
        test_complete_err();
        test_reset_mid_claim();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
